// File: rtl/render_pkg.sv
// Shared types and constants for the per-frame render sequencer.
// Holds the sequencer state encoding and the clear-word layout/defaults.
// No logic; imported by frame_sequencer.
package render_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    RUN,
    DRAIN,
    WAIT_VSYNC,
    SWAP
  } seq_state_t;

  // Clear word is {depth[7:0], rgb565[15:0]}
  localparam int CLEAR_W = 24;
  localparam logic [7:0]  CLEAR_Z_DEF   = 8'hFF;    // far plane
  localparam logic [15:0] CLEAR_RGB_DEF = 16'h0000; // black

endpackage

// File: rtl/clear_addr_gen.sv
// Purpose: pixel index generator for the framebuffer clear, counts 0..N-1.
// Latency: address advances on the edge a write is accepted (we & ready).
// Backpressure: ready=0 holds the address; done pulses combinationally on the final accepted write.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   we          clear write strobe currently presented
//   ready       framebuffer accepts the write this cycle
//   addr        current pixel index (registered)
//   done        final write (addr = N-1) is being accepted this cycle
module clear_addr_gen #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          ready,
  output logic [AW-1:0] addr,
  output logic          done
);

  logic last;

  assign last = (addr == AW'(N - 1));
  assign done = we & ready & last;

  // Wrapping to zero after the last write leaves the counter ready for the
  // next frame without an explicit load from the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (we && ready) begin
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Purpose: per-frame controller - clear back buffer, kick geometry, wait for drain, swap on vsync.
// Latency: enable->first clear write 1 cycle; last clear->geo_start 1; drain->wait 1; vsync rise->swap 1.
// Backpressure: clear writes stall on i_clear_ready=0 (addr/we held); drain waits for an idle pipeline.
//
// Ports:
//   i_clk, i_rst                  clock, async active-low reset
//   i_enable                      run frames continuously (sampled in IDLE and SWAP)
//   i_vsync                       display vsync level, rising edge used
//   o_geo_start / i_geo_done      geometry kick pulse / last-vertex pulse
//   i_fifo_empty, i_tri_valid,
//   i_raster_busy                 downstream activity used for the drain check
//   o_clear_we, i_clear_ready,
//   o_clear_addr, o_clear_buf,
//   o_clear_data                  framebuffer clear write port
//   o_front_buf, o_swap           scanned-out buffer select and swap pulse
//   o_busy                        not idle
//   o_frame_count, o_late_count   completed frames (wrap), vsyncs missed while rendering (saturate)
module frame_sequencer
  import render_pkg::*;
#(
  parameter int          FB_WIDTH     = 320,
  parameter int          FB_HEIGHT    = 240,
  parameter int          PIX_AW       = $clog2(FB_WIDTH * FB_HEIGHT),
  parameter logic [7:0]  CLEAR_Z      = CLEAR_Z_DEF,
  parameter logic [15:0] CLEAR_RGB    = CLEAR_RGB_DEF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_vsync,
  output logic               o_geo_start,
  input  logic               i_geo_done,
  input  logic               i_fifo_empty,
  input  logic               i_tri_valid,
  input  logic               i_raster_busy,
  output logic               o_clear_we,
  input  logic               i_clear_ready,
  output logic [PIX_AW-1:0]  o_clear_addr,
  output logic               o_clear_buf,
  output logic [CLEAR_W-1:0] o_clear_data,
  output logic               o_front_buf,
  output logic               o_swap,
  output logic               o_busy,
  output logic [15:0]        o_frame_count,
  output logic [15:0]        o_late_count
);

  localparam int N_PIX  = FB_WIDTH * FB_HEIGHT;
  localparam int IDLE_W = $clog2(DRAIN_CYCLES + 1);

  seq_state_t        state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
  logic              vsync_q;
  logic              vsync_rise;
  logic              pipe_idle;
  logic              clear_done;
  logic              front_nxt;
  logic              rendering;

  assign o_clear_data = {CLEAR_Z, CLEAR_RGB};

  assign vsync_rise = i_vsync & ~vsync_q;
  assign pipe_idle  = i_fifo_empty & ~i_tri_valid & ~i_raster_busy;
  assign rendering  = (state == CLEAR) || (state == START) ||
                      (state == RUN)   || (state == DRAIN);
  // Buffer select flips on the same edge that raises o_swap.
  assign front_nxt  = o_front_buf ^ (state_nxt == SWAP);

  clear_addr_gen #(
    .N  (N_PIX),
    .AW (PIX_AW)
  ) u_addr (
    .clk   (i_clk),
    .rst_n (i_rst),
    .we    (o_clear_we),
    .ready (i_clear_ready),
    .addr  (o_clear_addr),
    .done  (clear_done)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    case (state)
      IDLE:       if (i_enable) state_nxt = CLEAR;
      CLEAR:      if (clear_done) state_nxt = START;
      START:      state_nxt = RUN;
      RUN:        if (i_geo_done) state_nxt = DRAIN;
      DRAIN: begin
        // Any busy cycle restarts the consecutive-idle count from zero.
        if (pipe_idle) begin
          idle_cnt_nxt = idle_cnt + 1'b1;
          if (idle_cnt == IDLE_W'(DRAIN_CYCLES - 1)) state_nxt = WAIT_VSYNC;
        end
      end
      WAIT_VSYNC: if (vsync_rise) state_nxt = SWAP;
      SWAP:       state_nxt = i_enable ? CLEAR : IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vsync_q       <= 1'b0;
      idle_cnt      <= '0;
      o_clear_we    <= 1'b0;
      o_clear_buf   <= 1'b0;
      o_geo_start   <= 1'b0;
      o_swap        <= 1'b0;
      o_front_buf   <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_count <= '0;
      o_late_count  <= '0;
    end else begin
      vsync_q     <= i_vsync;
      idle_cnt    <= idle_cnt_nxt;
      o_clear_we  <= (state_nxt == CLEAR);
      o_clear_buf <= (state_nxt == CLEAR) & ~front_nxt;
      o_geo_start <= (state_nxt == START);
      o_swap      <= (state_nxt == SWAP);
      o_front_buf <= front_nxt;
      o_busy      <= (state_nxt != IDLE);
      if (state_nxt == SWAP) begin
        o_frame_count <= o_frame_count + 16'd1;
      end
      if (vsync_rise && rendering && (o_late_count != 16'hFFFF)) begin
        o_late_count <= o_late_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Per-frame controller for the render pipeline: clears the back depth/colour buffer, kicks the geometry engine, and waits for geometry, vertex FIFO, triangle assembler and rasterizer to drain. It then swaps front/back buffers on the next vsync rising edge. It sits beside the geometry → vertex_fifo → triangle_assembler → rasterizer chain and owns the framebuffer clear write port and the buffer-select bit.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels
FB_HEIGHT, 240, framebuffer height in pixels
PIX_AW, $clog2(FB_WIDTH*FB_HEIGHT), pixel index width (derived; do not override)
CLEAR_Z, 8'hFF, depth value written during clear (far plane)
CLEAR_RGB, 16'h0000, colour value written during clear
DRAIN_CYCLES, 4, consecutive idle cycles required to declare the pipeline drained (≥1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-low
i_enable  in  1  level; 1 = run frames continuously
i_vsync  in  1  display vsync level (synchronous to i_clk); rising edge used
o_geo_start  out  1  one-cycle pulse starting geometry for one frame
i_geo_done  in  1  one-cycle pulse: last vertex emitted
i_fifo_empty  in  1  vertex FIFO empty
i_tri_valid  in  1  assembler presenting a triangle
i_raster_busy  in  1  rasterizer busy
o_clear_we  out  1  clear write strobe
i_clear_ready  in  1  framebuffer accepts clear write this cycle
o_clear_addr  out  PIX_AW  clear pixel index
o_clear_buf  out  1  buffer being cleared (= back buffer)
o_clear_data  out  24  {CLEAR_Z, CLEAR_RGB}
o_front_buf  out  1  buffer currently scanned out
o_swap  out  1  one-cycle pulse on buffer swap
o_busy  out  1  1 in any state except IDLE
o_frame_count  out  16  completed frames, wraps at 16'hFFFF→0
o_late_count  out  16  vsync edges missed while rendering, saturates at 16'hFFFF

Behaviour:
- Reset (i_rst=0, async): state IDLE. Every output 0 except o_clear_data (constant). Counters cleared. vsync edge register cleared.
- vsync_rise = i_vsync & ~vsync_q; vsync_q is a registered copy of i_vsync.
- States:
  - IDLE: if i_enable, go to CLEAR with addr=0.
  - CLEAR: o_clear_we=1, o_clear_buf=~o_front_buf. A write completes on a cycle with we&ready; addr then increments. When the write at addr=N-1 (N=FB_WIDTH*FB_HEIGHT) completes, go to START. If ready=0, addr/we hold. Exactly N writes, no gaps other than ready stalls.
  - START: o_geo_start=1 for exactly this one cycle; go to RUN.
  - RUN: wait for i_geo_done; then go to DRAIN with idle_cnt=0. A geo_done in START or CLEAR is ignored.
  - DRAIN: idle = i_fifo_empty & ~i_tri_valid & ~i_raster_busy. If idle, idle_cnt++; otherwise idle_cnt=0. When idle_cnt reaches DRAIN_CYCLES, go to WAIT_VSYNC.
  - WAIT_VSYNC: on vsync_rise go to SWAP.
  - SWAP (1 cycle): o_front_buf toggles and o_swap=1 in the same cycle; o_frame_count++. Next state is CLEAR if i_enable, else IDLE.
- o_late_count increments on vsync_rise while in CLEAR, START, RUN or DRAIN.
- i_enable deasserted mid-frame: the current frame completes through SWAP, then the block goes to IDLE. Enable is sampled only in IDLE and SWAP.
- o_busy is registered from the state: 0 in IDLE, 1 otherwise.
- Latency:
  - IDLE→first clear write: 1 cycle.
  - Last clear write→o_geo_start: 1 cycle.
  - Drain satisfied→WAIT_VSYNC: 1 cycle.
  - vsync_rise→o_swap: 1 cycle.
- All outputs are registered except o_clear_data, which is constant.

Decomposition:
- Package render_pkg: typedef enum logic [2:0] seq_state_t {IDLE, CLEAR, START, RUN, DRAIN, WAIT_VSYNC, SWAP}; clear-word width constant (24); CLEAR_Z/CLEAR_RGB defaults.
- One natural sub-module: clear_addr_gen (counter 0..N-1 with ready stall and a done pulse). Everything else stays in frame_sequencer.

Test Plan:
- FB 4x2, ready=1, enable=1 → 8 consecutive writes addr 0..7 with o_clear_buf=1. o_geo_start pulses exactly once, 1 cycle after the addr=7 write.
- Clear with ready toggling 1,0,1,0… → still exactly 8 accepted writes, no address skipped or repeated, addr held during ready=0.
- geo_done, then raster_busy drops and rises again after 2 idle cycles (DRAIN_CYCLES=4) → idle_cnt resets and WAIT_VSYNC is entered only after 4 consecutive idle cycles.
- Two vsync rises during RUN, one in WAIT_VSYNC → o_late_count=2. o_swap fires 1 cycle after the third rise. o_front_buf 0→1, o_frame_count=1.
- Drop enable during RUN → frame completes, o_swap fires, state returns to IDLE, o_busy=0, no further o_geo_start.
- Assert i_rst=0 mid-CLEAR (asynchronous, between clock edges) → outputs go to 0 immediately. After release with enable=1, the clear restarts at addr 0 with o_front_buf=0.
